aether_cmd_sequencer: RTL and testbench
=======================================

Name: aether_cmd_sequencer

Overview:
Upstream command-issue stage for aether_engine. It buffers host commands in a FIFO and drives the engine's instruction_i/param_1_i/param_2_i bus one command per cycle, inserting NOP when idle. Commands flagged "wait" stall the queue until the engine's interrupt_o rises. The block then auto-issues {RDR, REG_STATS, 16'h0000} to clear the interrupt and captures the returned status word. This replaces hand-sequenced execute_cmd/@(posedge interrupt) flows.

Parameters:
FifoDepth, 16, command FIFO entries (power of two, >=2)
ReadLatency, 2, cycles from RDR issue cycle to data_i valid for capture
TimeoutCycles, 0, max cycles in WAIT_IRQ before abort; 0 disables timeout

Ports:
clk_i  input  1  clock (same domain as aether_engine clk_i)
rst_i  input  1  synchronous active-high reset
host_cmd_i  input  24  {instruction[3:0], param_1[3:0], param_2[15:0]}
host_wait_i  input  1  after issuing this command, stall until interrupt, then read REG_STATS
host_valid_i  input  1  host command valid
host_ready_o  output  1  FIFO can accept; push = valid & ready
flush_i  input  1  drop all queued commands, abort any wait
instruction_o  output  4  to engine instruction_i
param_1_o  output  4  to engine param_1_i
param_2_o  output  16  to engine param_2_i
interrupt_i  input  1  from engine interrupt_o
data_i  input  16  from engine data_o
status_o  output  16  last captured REG_STATS value
status_valid_o  output  1  one-cycle pulse when status_o updates
busy_o  output  1  FIFO non-empty or FSM not in IDLE
timeout_o  output  1  sticky: a wait exceeded TimeoutCycles
fifo_count_o  output  $clog2(FifoDepth+1)  current FIFO occupancy

Behaviour:
- Reset: FIFO empty, FSM IDLE. Outputs: instruction/param = NOP (24'h0), status_o=0, status_valid_o=0, busy_o=0, timeout_o=0, host_ready_o=1, fifo_count_o=0. Reset mid-operation abandons any wait without issuing RDR.
- All engine-bus outputs are registered. Every cycle not issuing a command drives {NOP, 4'h0, 16'h0}.
- FIFO push and pop use first-word-fall-through. A push accepted at edge k with an idle, empty FIFO gets popped at edge k+1. The command is driven during the cycle after edge k+1. Push and pop in the same cycle are allowed, and the count is unchanged. host_ready_o = (count != FifoDepth). A push while full is ignored.
- FSM states:
  - IDLE: if FIFO non-empty, pop and load the outputs. If wait=0, stay in IDLE, giving back-to-back issue at 1 command/cycle. If wait=1, go to WAIT_IRQ.
  - WAIT_IRQ: outputs NOP and no pops. Advance to READ_STAT on irq_seen.
  - READ_STAT: drive {RDR, REG_STATS, 16'h0000} for exactly one cycle, then go to CAPTURE.
  - CAPTURE: count ReadLatency cycles from the RDR cycle. On the last count, latch data_i into status_o, pulse status_valid_o, and return to IDLE. The next pop may occur on that same edge.
- Interrupt detection: irq_q registers interrupt_i. Edge = interrupt_i & ~irq_q. irq_seen is set by an edge during the issue cycle of the wait command or during WAIT_IRQ. irq_seen clears on leaving WAIT_IRQ. A level already high before the wait command was issued does not satisfy the wait.
- Timeout: if TimeoutCycles != 0, count the cycles spent in WAIT_IRQ. When the count reaches TimeoutCycles without irq_seen, set timeout_o (sticky until reset), skip READ_STAT and CAPTURE, and return to IDLE. status_o is unchanged. An edge on the same cycle as expiry counts as a success, and the timeout is not flagged.
- Flush: on the next edge the FIFO empties and the FSM goes to IDLE with NOP outputs. A pending RDR/capture is dropped, and status_valid_o is not pulsed. If flush and push occur together, flush wins and the push is discarded. A command already on the bus in the flush cycle completes normally (it was issued the previous edge).
- busy_o = (count != 0) | (state != IDLE), registered with the state.

Test Plan:
- Reset -> cycle after rst_i low: instruction/param = 0, host_ready_o=1, fifo_count_o=0, busy_o=0, timeout_o=0.
- Push {WRR,REG_BCFG1,16'h4002}, {WRR,REG_BCFG2,16'h0004}, {WRR,REG_CPRM1,16'h0040} on three consecutive edges, wait=0 -> the three commands appear on consecutive cycles starting 2 edges after the first push, then NOP.
- Push {CNV,20'h0} with wait=1, then {LDW,LDW_CWGT,16'h0000}; the engine model raises interrupt 40 cycles later with data_i=16'h0001 -> bus holds NOP, then one cycle of {RDR,REG_STATS,16'h0000}. ReadLatency cycles later status_o=16'h0001 with a single status_valid_o pulse. LDW issues after that.
- Stall in WAIT_IRQ and push 17 commands -> host_ready_o=0 at count 16, 17th not accepted, fifo_count_o=16.
- TimeoutCycles=100, wait command with no interrupt -> timeout_o rises 100 cycles into WAIT_IRQ and stays high, no RDR is issued, and the next queued command issues.
- flush_i during WAIT_IRQ with 5 queued -> next cycle fifo_count_o=0, NOP output, busy_o=0. A later interrupt edge triggers no RDR.

Source files
------------

// File: rtl/aether_cmd_sequencer_if.sv
// Command/engine bus bundle for aether_cmd_sequencer.
//   host side  : host_cmd_i, host_wait_i, host_valid_i -> host_ready_o
//   engine side: instruction_o, param_1_o, param_2_o -> engine inputs;
//                interrupt_i, data_i <- engine outputs
// The slave modport is the sequencer's view, master is the host/engine side.
interface aether_cmd_sequencer_if;
  logic [23:0] host_cmd_i;
  logic        host_wait_i;
  logic        host_valid_i;
  logic        host_ready_o;
  logic [3:0]  instruction_o;
  logic [3:0]  param_1_o;
  logic [15:0] param_2_o;
  logic        interrupt_i;
  logic [15:0] data_i;

  modport slave (
    input  host_cmd_i, host_wait_i, host_valid_i, interrupt_i, data_i,
    output host_ready_o, instruction_o, param_1_o, param_2_o
  );

  modport master (
    output host_cmd_i, host_wait_i, host_valid_i, interrupt_i, data_i,
    input  host_ready_o, instruction_o, param_1_o, param_2_o
  );
endinterface

// File: rtl/aether_cmd_sequencer.sv
// Command-issue stage in front of aether_engine. Buffers host commands in a
// first-word-fall-through FIFO and issues one per cycle on the engine bus
// (NOP when idle). A command flagged "wait" stalls issue until the engine
// interrupt rises, then the block issues {RDR, REG_STATS, 0} and captures
// the returned status word ReadLatency cycles after the RDR cycle.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   bus (slave)        host command push + engine instruction/interrupt/data
//   flush_i            drop queue and abort any wait / pending read
//   status_o           last captured REG_STATS word
//   status_valid_o     one-cycle pulse when status_o updates
//   busy_o             queue non-empty or sequencer not idle
//   timeout_o          sticky: a wait expired without an interrupt
//   fifo_count_o       current queue occupancy
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | pop and issue queued commands, one per cycle
// S_WAIT_IRQ  | wait command issued; NOP on the bus until interrupt edge
// S_READ_STAT | RDR REG_STATS on the bus for exactly one cycle
// S_CAPTURE   | counting read latency; latch data_i on the last count
module aether_cmd_sequencer #(
  parameter int unsigned FifoDepth     = 16,
  parameter int unsigned ReadLatency   = 2,
  parameter int unsigned TimeoutCycles = 0,
  parameter logic [3:0]  OpRdr         = 4'h4,
  parameter logic [3:0]  RegStats      = 4'hF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  aether_cmd_sequencer_if.slave              bus,
  input  logic                               flush_i,
  output logic [15:0]                        status_o,
  output logic                               status_valid_o,
  output logic                               busy_o,
  output logic                               timeout_o,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_count_o
);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);
  localparam int unsigned LatW  = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
  localparam int unsigned TmoW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic        TmoEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IRQ, S_READ_STAT, S_CAPTURE} state_t;
  state_t state_q, state_d;

  // Each entry is {wait, command}.
  logic [24:0]     fifo_mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [24:0]     head;
  logic            fifo_empty, push, pop, pop_ok;

  logic            irq_q, irq_edge, irq_seen_q, irq_hit;
  logic [LatW-1:0] lat_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic            lat_done, tmo_expired;

  logic [23:0]     bus_d, bus_q;
  logic            capture, set_timeout;

  assign head             = fifo_mem[rd_ptr_q];
  assign fifo_empty       = (count_q == '0);
  assign bus.host_ready_o = (count_q != CntW'(FifoDepth));
  assign push             = bus.host_valid_i & bus.host_ready_o & ~flush_i;
  assign lat_done         = (lat_cnt_q == '0);
  assign tmo_expired      = TmoEn & (tmo_cnt_q == '0);
  // The last capture cycle frees the bus, so the next pop can share that edge.
  assign pop_ok           = (state_q == S_IDLE) | ((state_q == S_CAPTURE) & lat_done);
  assign pop              = pop_ok & ~fifo_empty & ~flush_i;
  assign irq_edge         = bus.interrupt_i & ~irq_q;
  // irq_seen_q holds an edge that arrived while the wait command was being popped.
  assign irq_hit          = (state_q == S_WAIT_IRQ) & (irq_seen_q | irq_edge);

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.host_wait_i, bus.host_cmd_i};
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)            count_d = '0;
    else if (push && !pop)  count_d = count_q + CntW'(1);
    else if (pop && !push)  count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (pop) state_d = head[24] ? S_WAIT_IRQ : S_IDLE;
        S_WAIT_IRQ: begin
          if (irq_hit)          state_d = S_READ_STAT;
          else if (tmo_expired) state_d = S_IDLE;
        end
        S_READ_STAT: state_d = S_CAPTURE;
        S_CAPTURE:   if (lat_done) state_d = (pop && head[24]) ? S_WAIT_IRQ : S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_d       = '0;
    capture     = 1'b0;
    set_timeout = 1'b0;
    if (!flush_i) begin
      if (pop)          bus_d = head[23:0];
      else if (irq_hit) bus_d = {OpRdr, RegStats, 16'h0000};
      capture     = (state_q == S_CAPTURE) & lat_done;
      set_timeout = (state_q == S_WAIT_IRQ) & ~irq_hit & tmo_expired;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_q          <= '0;
      status_o       <= '0;
      status_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
      irq_q          <= 1'b0;
      irq_seen_q     <= 1'b0;
      lat_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      bus_q          <= bus_d;
      irq_q          <= bus.interrupt_i;
      status_valid_o <= capture;
      if (capture)     status_o  <= bus.data_i;
      if (set_timeout) timeout_o <= 1'b1;
      busy_o <= (count_d != '0) | (state_d != S_IDLE);

      if (flush_i || state_q == S_WAIT_IRQ)  irq_seen_q <= 1'b0;
      else if (pop && head[24] && irq_edge)  irq_seen_q <= 1'b1;

      if (state_q == S_READ_STAT)
        lat_cnt_q <= LatW'(ReadLatency - 1);
      else if (state_q == S_CAPTURE && !lat_done)
        lat_cnt_q <= lat_cnt_q - LatW'(1);

      // Preloaded outside the wait so the first WAIT_IRQ cycle counts as one.
      if (state_q != S_WAIT_IRQ)
        tmo_cnt_q <= TmoW'(TimeoutCycles - 1);
      else if (!tmo_expired)
        tmo_cnt_q <= tmo_cnt_q - TmoW'(1);
    end
  end

  assign bus.instruction_o = bus_q[23:20];
  assign bus.param_1_o     = bus_q[19:16];
  assign bus.param_2_o     = bus_q[15:0];
  assign fifo_count_o      = count_q;
endmodule

// File: tb/tb_aether_cmd_sequencer.sv
module tb_aether_cmd_sequencer;
  localparam int DEPTH = 16;
  localparam int RL    = 2;
  localparam int TMO   = 100;

  localparam logic [3:0] OP_LDW = 4'h1, OP_CNV = 4'h2, OP_WRR = 4'h3, OP_RDR = 4'h4;
  localparam logic [3:0] REG_BCFG1 = 4'h1, REG_BCFG2 = 4'h2, REG_CPRM1 = 4'h3;
  localparam logic [3:0] REG_STATS = 4'hF, LDW_CWGT = 4'h0;
  localparam logic [23:0] RDR_WORD = {OP_RDR, REG_STATS, 16'h0000};

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [15:0] status_o;
  logic        status_valid_o, busy_o, timeout_o;
  logic [4:0]  fifo_count_o;

  aether_cmd_sequencer_if sif ();

  aether_cmd_sequencer #(
    .FifoDepth(DEPTH), .ReadLatency(RL), .TimeoutCycles(TMO),
    .OpRdr(OP_RDR), .RegStats(REG_STATS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(sif.slave), .flush_i(flush_i),
    .status_o(status_o), .status_valid_o(status_valid_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference: a queue of pending commands plus timestamps
  // for the outstanding wait and status read.
  logic [24:0] mq[$];
  int          m_cyc = 0;
  bit          m_waiting = 0, m_pre_seen = 0, m_irq_prev = 0;
  int          m_wait_from = 0, m_rdr_at = -1;
  logic [23:0] e_bus = '0;
  logic [15:0] e_status = '0;
  bit          e_sv = 0, e_tmo = 0, e_busy = 0, e_ready = 1;
  int          e_count = 0;
  bit          data_rand = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_edge();
    bit          edge_now, acc, can_pop;
    int          sz;
    logic [24:0] e;
    edge_now = sif.interrupt_i && !m_irq_prev;
    if (rst_i) begin
      mq.delete();
      m_waiting = 0; m_pre_seen = 0; m_rdr_at = -1; m_irq_prev = 0;
      e_bus = '0; e_status = '0; e_sv = 0; e_tmo = 0;
    end else begin
      m_irq_prev = sif.interrupt_i;
      e_bus = '0;
      e_sv  = 0;
      sz  = mq.size();
      acc = sif.host_valid_i && (sz != DEPTH);
      if (flush_i) begin
        mq.delete();
        m_waiting = 0; m_pre_seen = 0; m_rdr_at = -1;
      end else begin
        can_pop = 0;
        if (m_waiting) begin
          if (m_pre_seen || edge_now) begin
            m_waiting = 0; m_pre_seen = 0;
            m_rdr_at = m_cyc + 1;
            e_bus = RDR_WORD;
          end else if (TMO != 0 && (m_cyc - m_wait_from + 1) >= TMO) begin
            m_waiting = 0;
            e_tmo = 1;
          end
        end else if (m_rdr_at >= 0) begin
          if (m_cyc == m_rdr_at + RL) begin
            e_status = sif.data_i;
            e_sv = 1;
            m_rdr_at = -1;
            can_pop = 1;
          end
        end else begin
          can_pop = 1;
        end
        if (can_pop && sz != 0) begin
          e = mq.pop_front();
          e_bus = e[23:0];
          if (e[24]) begin
            m_waiting = 1;
            m_wait_from = m_cyc + 1;
            m_pre_seen = edge_now;
          end
        end
        if (acc) mq.push_back({sif.host_wait_i, sif.host_cmd_i});
      end
    end
    e_busy  = (mq.size() != 0) || m_waiting || (m_rdr_at >= 0);
    e_count = mq.size();
    e_ready = (mq.size() != DEPTH);
    m_cyc++;
  endtask

  task automatic check_outputs();
    check_eq("bus", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, {8'h0, e_bus});
    check_eq("status", {16'h0, status_o}, {16'h0, e_status});
    check_eq("status_valid", {31'h0, status_valid_o}, {31'h0, e_sv});
    check_eq("busy", {31'h0, busy_o}, {31'h0, e_busy});
    check_eq("timeout", {31'h0, timeout_o}, {31'h0, e_tmo});
    check_eq("host_ready", {31'h0, sif.host_ready_o}, {31'h0, e_ready});
    check_eq("fifo_count", {27'h0, fifo_count_o}, 32'(e_count));
  endtask

  // Inputs are driven at the negedge before calling; outputs checked at the next negedge.
  task automatic cycle();
    if (data_rand) sif.data_i = 16'($urandom);
    model_edge();
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
    if (sif.instruction_o == OP_RDR) sif.interrupt_i = 1'b0;  // engine clears on RDR
  endtask

  task automatic push(input logic [23:0] cmd, input logic w);
    sif.host_valid_i = 1'b1;
    sif.host_cmd_i   = cmd;
    sif.host_wait_i  = w;
    cycle();
  endtask

  int n_rdr, n_sv;
  bit saw_ldw;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    sif.host_cmd_i = '0; sif.host_wait_i = 1'b0; sif.host_valid_i = 1'b0;
    sif.interrupt_i = 1'b0; sif.data_i = '0;
    repeat (3) cycle();
    rst_i = 1'b0;
    cycle();
    check_eq("rst_bus", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, 32'h0);
    check_eq("rst_ready", {31'h0, sif.host_ready_o}, 32'h1);
    check_eq("rst_count", {27'h0, fifo_count_o}, 32'h0);

    // Back-to-back issue.
    push({OP_WRR, REG_BCFG1, 16'h4002}, 1'b0);
    push({OP_WRR, REG_BCFG2, 16'h0004}, 1'b0);
    check_eq("b2b_1", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, {8'h0, OP_WRR, REG_BCFG1, 16'h4002});
    push({OP_WRR, REG_CPRM1, 16'h0040}, 1'b0);
    check_eq("b2b_2", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, {8'h0, OP_WRR, REG_BCFG2, 16'h0004});
    sif.host_valid_i = 1'b0;
    cycle();
    check_eq("b2b_3", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, {8'h0, OP_WRR, REG_CPRM1, 16'h0040});
    cycle();
    check_eq("b2b_nop", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, 32'h0);

    // Wait command, interrupt 40 cycles later, status read.
    data_rand = 0; sif.data_i = 16'h0001;
    push({OP_CNV, 20'h0}, 1'b1);
    push({OP_LDW, LDW_CWGT, 16'h0000}, 1'b0);
    sif.host_valid_i = 1'b0;
    n_rdr = 0;
    repeat (40) begin
      cycle();
      if (sif.instruction_o == OP_RDR) n_rdr++;
    end
    check_eq("wait_no_rdr", 32'(n_rdr), 32'h0);
    sif.interrupt_i = 1'b1;
    n_sv = 0; saw_ldw = 0;
    repeat (8) begin
      cycle();
      if (sif.instruction_o == OP_RDR) n_rdr++;
      if (status_valid_o) n_sv++;
      if (sif.instruction_o == OP_LDW) saw_ldw = 1;
    end
    check_eq("wait_rdr_once", 32'(n_rdr), 32'h1);
    check_eq("wait_sv_once", 32'(n_sv), 32'h1);
    check_eq("wait_status", {16'h0, status_o}, 32'h0001);
    check_eq("wait_ldw", {31'h0, saw_ldw}, 32'h1);
    data_rand = 1;

    // Fill the queue while stalled.
    push({OP_CNV, 20'h0}, 1'b1);
    for (int j = 0; j < 17; j++) push({OP_WRR, 4'(j), 16'(j * 3)}, 1'b0);
    sif.host_valid_i = 1'b0;
    check_eq("full_count", {27'h0, fifo_count_o}, 32'd16);
    check_eq("full_ready", {31'h0, sif.host_ready_o}, 32'h0);
    sif.interrupt_i = 1'b1;
    repeat (30) cycle();
    check_eq("drain_count", {27'h0, fifo_count_o}, 32'h0);
    check_eq("drain_busy", {31'h0, busy_o}, 32'h0);

    // Timeout with no interrupt.
    push({OP_CNV, 20'h0}, 1'b1);
    push({OP_WRR, REG_BCFG1, 16'hBEEF}, 1'b0);
    sif.host_valid_i = 1'b0;
    repeat (99) cycle();
    check_eq("tmo_before", {31'h0, timeout_o}, 32'h0);
    cycle();
    check_eq("tmo_set", {31'h0, timeout_o}, 32'h1);
    check_eq("tmo_nop", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, 32'h0);
    cycle();
    check_eq("tmo_next", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, {8'h0, OP_WRR, REG_BCFG1, 16'hBEEF});
    repeat (3) cycle();

    // Flush during a wait with five queued.
    push({OP_CNV, 20'h0}, 1'b1);
    for (int j = 0; j < 5; j++) push({OP_WRR, 4'(j), 16'h1111}, 1'b0);
    sif.host_valid_i = 1'b0;
    check_eq("pre_flush_count", {27'h0, fifo_count_o}, 32'd5);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check_eq("flush_count", {27'h0, fifo_count_o}, 32'h0);
    check_eq("flush_busy", {31'h0, busy_o}, 32'h0);
    check_eq("flush_nop", {8'h0, sif.instruction_o, sif.param_1_o, sif.param_2_o}, 32'h0);
    sif.interrupt_i = 1'b1;
    n_rdr = 0;
    repeat (10) begin
      cycle();
      if (sif.instruction_o == OP_RDR) n_rdr++;
    end
    check_eq("flush_no_rdr", 32'(n_rdr), 32'h0);
    sif.interrupt_i = 1'b0;

    rst_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();
    check_eq("rst2_timeout", {31'h0, timeout_o}, 32'h0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      sif.host_valid_i = ($urandom_range(0, 99) < 45);
      sif.host_cmd_i   = 24'($urandom);
      sif.host_wait_i  = ($urandom_range(0, 99) < 12);
      flush_i          = ($urandom_range(0, 299) == 0);
      rst_i            = (i == 1500 || i == 1501);
      if (!sif.interrupt_i && $urandom_range(0, 39) == 0)     sif.interrupt_i = 1'b1;
      else if (sif.interrupt_i && $urandom_range(0, 29) == 0) sif.interrupt_i = 1'b0;
      cycle();
    end
    rst_i = 1'b0; flush_i = 1'b0; sif.host_valid_i = 1'b0;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
